soc_system_pio_edge_in: RTL
===========================

SOC_SYSTEM_PIO_EDGE_IN -- requirements
Module: soc_system_pio_edge_in

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, input port width, legal 1..32.
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, synchronizer depth, legal 2..3.
REQ-003 SHALL provide parameter EDGE_MODE, default 0, edge type captured: 0 rising, 1 falling, 2 any.
REQ-004 SHALL provide parameter CNT_W, default 16, event counter width, legal 1..32.
REQ-005 SHALL have ports:
- clk  input  1  clock
- reset_n  input  1  reset, asynchronous, active-low
- address  input  2  Avalon-MM register select
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe
- writedata  input  32  write data
- in_port  input  WIDTH  asynchronous external inputs
- readdata  output  32  registered read data
- irq  output  1  level interrupt, active-high

Function
REQ-006 SHALL define write_en = chipselect & ~write_n; chipselect/write_n are ignored for reads.
REQ-007 SHALL pass in_port through SYNC_STAGES flops (sync), then one more flop (prev); all reset to 0.
REQ-008 SHALL compute per-bit edge: mode 0 sync & ~prev; mode 1 ~sync & prev; mode 2 sync ^ prev.
REQ-009 SHALL map registers: 0 DATA (RO, = sync), 1 MASK (RW, WIDTH bits), 2 EDGECAP (W1C, WIDTH bits), 3 COUNT (RO count, any write clears).
REQ-010 SHALL update readdata every clk with the selected register, zero-extended to 32 bits; one-cycle read latency, no wait states.
REQ-011 SHALL ignore writes to address 0; MASK loads writedata[WIDTH-1:0] on write to address 1.
REQ-012 SHALL update EDGECAP <= (EDGECAP & ~clr) | edge, clr = writedata[WIDTH-1:0] when write to address 2, else 0; a same-cycle edge beats the clear.
REQ-013 SHALL increment COUNT by exactly 1 in any cycle where |edge = 1, regardless of how many bits edged.
REQ-014 SHALL saturate COUNT at 2^CNT_W-1, no wrap.
REQ-015 SHALL, on write to address 3, load COUNT with 1 if |edge that cycle, else 0.
REQ-016 SHALL drive irq = |(EDGECAP & MASK) from registered state, no added delay.
REQ-017 SHALL, with in_port change first sampled at edge k: DATA valid after edge k+SYNC_STAGES-1, EDGECAP bit and irq set at edge k+SYNC_STAGES, COUNT incremented at edge k+SYNC_STAGES.
REQ-018 SHALL capture a pulse on in_port only if at least one clk edge samples it; shorter pulses may be lost without error.

Reset
REQ-019 SHALL asynchronously clear sync, prev, MASK, EDGECAP, COUNT, readdata to 0 and deassert irq on reset_n low.
REQ-020 SHALL, after reset release, treat inputs held high as rising edges (prev = 0), captured SYNC_STAGES cycles later in modes 0 and 2.
REQ-021 SHALL abort any in-progress capture or write on reset assertion mid-operation; no state survives reset.

Verification
REQ-022 SHALL test: WIDTH=4, mode 0, in_port 0->4'h5 at edge k, address 0 -> readdata 32'h5 after edge k+2; EDGECAP 4'h5, COUNT 1.
REQ-023 SHALL test: MASK=4'h1, EDGECAP=4'h5 -> irq=1; write 4'h1 to address 2 -> EDGECAP 4'h4, irq=0 next cycle.
REQ-024 SHALL test: W1C of bit 0 in the same cycle as a new bit-0 edge -> EDGECAP bit 0 stays 1, irq stays high.
REQ-025 SHALL test: CNT_W=2, toggle bit 0 five times in mode 2 -> COUNT saturates at 3; write to address 3 -> COUNT 0.
REQ-026 SHALL test: mode 1, in_port 4'hF held through reset release, then 4'h0 -> no capture at release, EDGECAP 4'hF after fall.
REQ-027 SHALL test: reset_n pulsed low mid-capture with MASK=4'hF -> irq, readdata, EDGECAP, COUNT all 0 immediately, asynchronous to clk.

Source files
------------

// File: rtl/soc_system_pio_edge_in_if.sv
// Avalon-MM slave bus bundle for the edge-capture PIO: register select, write strobe,
// data paths and the level interrupt.
interface soc_system_pio_edge_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/soc_system_pio_edge_in.sv
// Edge-capturing parallel input port: synchronises in_port, latches selected edges into a
// W1C capture register, counts edge cycles and raises a maskable level interrupt.
module soc_system_pio_edge_in #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_MODE   = 0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  soc_system_pio_edge_in_if.slave bus,
  input  logic [WIDTH-1:0]       in_port
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] clr;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rd_mux;
  logic             write_en;
  logic             any_edge;
  logic             unused_wdata;

  assign write_en     = bus.chipselect & ~bus.write_n;
  assign sync         = sync_q[SYNC_STAGES-1];
  assign any_edge     = |edge_det;
  assign unused_wdata = ^bus.writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev_q <= sync;
    end
  end

  always_comb begin
    if (EDGE_MODE == 0) begin
      edge_det = sync & ~prev_q;
    end else if (EDGE_MODE == 1) begin
      edge_det = ~sync & prev_q;
    end else begin
      edge_det = sync ^ prev_q;
    end
  end

  always_comb begin
    mask_d = mask_q;
    if (write_en && bus.address == 2'd1) mask_d = bus.writedata[WIDTH-1:0];

    clr = '0;
    if (write_en && bus.address == 2'd2) clr = bus.writedata[WIDTH-1:0];
    // OR-ing the new edge last lets a same-cycle edge win over the clear
    cap_d = (cap_q & ~clr) | edge_det;

    cnt_d = cnt_q;
    if (write_en && bus.address == 2'd3) begin
      cnt_d    = '0;
      cnt_d[0] = any_edge;
    end else if (any_edge && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (bus.address)
      2'd0: rd_mux[WIDTH-1:0] = sync;
      2'd1: rd_mux[WIDTH-1:0] = mask_q;
      2'd2: rd_mux[WIDTH-1:0] = cap_q;
      2'd3: rd_mux[CNT_W-1:0] = cnt_q;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q       <= '0;
      cap_q        <= '0;
      cnt_q        <= '0;
      bus.readdata <= '0;
    end else begin
      mask_q       <= mask_d;
      cap_q        <= cap_d;
      cnt_q        <= cnt_d;
      bus.readdata <= rd_mux;
    end
  end

  assign bus.irq = |(cap_q & mask_q);

endmodule
